// File: rtl/pending_priority_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the pending priority arbiter.
//   NUM_SRC : number of event sources
//   IDX_W   : width of a source index
//   state_t : two-state offer FSM encoding
package pending_priority_arbiter_pkg;

    localparam int NUM_SRC = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // One-hot vector with the bit at position idx set.
    function automatic logic [NUM_SRC-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_SRC-1:0] v;
        v = {{(NUM_SRC-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

endpackage

// File: rtl/pending_priority_arbiter_if.sv
// Handshake/bus bundle for the pending priority arbiter.
//   req, mask, out_ready, clr_ovf : driven by the environment (master)
//   out_valid, out_idx, pending, ovf : driven by the arbiter (slave)
interface pending_priority_arbiter_if;
    import pending_priority_arbiter_pkg::*;

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] mask;
    logic               out_ready;
    logic               clr_ovf;
    logic               out_valid;
    logic [IDX_W-1:0]   out_idx;
    logic [NUM_SRC-1:0] pending;
    logic               ovf;

    modport master (
        output req, mask, out_ready, clr_ovf,
        input  out_valid, out_idx, pending, ovf
    );

    modport slave (
        input  req, mask, out_ready, clr_ovf,
        output out_valid, out_idx, pending, ovf
    );

endinterface

// File: rtl/pending_priority_arbiter_prio_enc8.sv
// Fixed-priority encoder, bit 0 highest.
//   vec_i : candidate vector
//   idx_o : index of the lowest set bit (0 when none)
//   any_o : at least one bit of vec_i is set
module prio_enc8
    import pending_priority_arbiter_pkg::*;
(
    input  logic [NUM_SRC-1:0] vec_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // Scan from the lowest priority upward so the highest-priority hit wins.
    always_comb begin
        idx_o = {IDX_W{1'b0}};
        any_o = |vec_i;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end else begin
                idx_o = idx_o;
            end
        end
    end

endmodule

// File: rtl/pending_priority_arbiter.sv
// Pending-event priority arbiter: latches per-source event pulses into a
// pending register and offers the highest-priority unmasked index downstream
// with a valid/ready handshake; flags lost events in a sticky ovf bit.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of pending_priority_arbiter_if
//         (req, mask, out_ready, clr_ovf in; out_valid, out_idx, pending, ovf out)
module pending_priority_arbiter
    import pending_priority_arbiter_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    pending_priority_arbiter_if.slave       bus
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic               ovf_q, ovf_d;

    logic               accept_s;
    logic [NUM_SRC-1:0] clr_vec_s;
    logic [NUM_SRC-1:0] sel_vec_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic               sel_any_s;
    logic               ovf_set_s;

    // Pending update: accepted bit cleared, new requests OR'd in last so set wins.
    always_comb begin
        accept_s  = (state_q == ST_OFFER) && bus.out_ready;
        clr_vec_s = accept_s ? idx_onehot(idx_q) : {NUM_SRC{1'b0}};
        pending_d = (pending_q & ~clr_vec_s) | bus.req;
        ovf_set_s = |(bus.req & pending_q & ~clr_vec_s);
    end

    // Selection looks at the next pending value so a request is offered on the same edge it lands.
    assign sel_vec_s = pending_d & ~bus.mask;

    prio_enc8 u_prio_enc8 (
        .vec_i (sel_vec_s),
        .idx_o (sel_idx_s),
        .any_o (sel_any_s)
    );

    // Offer FSM: an offer is frozen until accepted, then the next winner loads immediately.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_any_s) begin
                    state_d = ST_OFFER;
                    idx_d   = sel_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (bus.out_ready && sel_any_s) begin
                    state_d = ST_OFFER;
                    idx_d   = sel_idx_s;
                end else if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OFFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Sticky overflow: a lost event outranks a simultaneous clear request.
    always_comb begin
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State, index, pending and overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= {IDX_W{1'b0}};
            pending_q <= {NUM_SRC{1'b0}};
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.out_valid = (state_q == ST_OFFER);
    assign bus.out_idx   = idx_q;
    assign bus.pending   = pending_q;
    assign bus.ovf       = ovf_q;

endmodule
